// File: rtl/hex_output_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : hex_output_driver_if
//  Description : Write channel from the processor core into the board
//                output driver. A transfer happens on a rising clock edge
//                while wr_valid and wr_ready are both high.
//                  wr_valid  master -> slave   write request
//                  wr_ready  slave  -> master  able to accept a write
//                  wr_sel    master -> slave   0=value 1=tag 2=control 3=rsvd
//                  wr_data   master -> slave   10-bit payload
//  Revision    : 1.0  initial release
// ============================================================================
interface hex_output_driver_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_sel;
    logic [9:0] wr_data;

    modport master (output wr_valid, output wr_sel, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_sel, input  wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/hex_output_driver.sv
`default_nettype none
// ============================================================================
//  Module      : hex_output_driver
//  Description : Takes 10-bit result writes from the processor core and
//                shows them on the board: binary on LED_B, decimal with
//                leading-zero blanking on HEX3..HEX0 (sequential
//                double-dabble conversion), a two-digit hex tag on
//                HEX5..HEX4, plus blink and blank controls.
//  Ports       : CLK        system clock
//                RSTb       asynchronous active-low reset
//                wr         write channel (slave side of hex_output_driver_if)
//                LED_B      last committed value, binary
//                HEX0..HEX5 active-low segments {dp,g,f,e,d,c,b,a}, dp off
//  Revision    : 1.0  initial release
// ============================================================================
module hex_output_driver #(
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 2
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    hex_output_driver_if.slave   wr,
    output logic [9:0]           LED_B,
    output logic [7:0]           HEX0,
    output logic [7:0]           HEX1,
    output logic [7:0]           HEX2,
    output logic [7:0]           HEX3,
    output logic [7:0]           HEX4,
    output logic [7:0]           HEX5
);

    // Blink half-period in clock cycles, never below one cycle.
    localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
    localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
    localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] BLINK_TERM = CW'(HALF - 1);

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    bin_q, bin_d;          // binary bits still to shift out
    logic [15:0]   bcd_q, bcd_d;          // conversion accumulator
    logic [3:0]    step_q, step_d;
    logic [9:0]    val_q, val_d;          // value under conversion
    logic [15:0]   digits_q, digits_d;    // committed decimal digits
    logic [9:0]    led_q, led_d;
    logic [7:0]    tag_q, tag_d;
    logic          tag_vld_q, tag_vld_d;
    logic          blink_en_q, blink_en_d;
    logic          blank_q, blank_d;
    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    logic          w_accept;
    logic          w_ctrl_wr;
    logic [15:0]   w_bcd_adj;
    logic          w_hide;

    assign wr.wr_ready = (state_q == IDLE);
    assign w_accept    = wr.wr_valid && (state_q == IDLE);
    assign w_ctrl_wr   = w_accept && (wr.wr_sel == 2'd2);

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 so the
    // following left shift carries correctly into the next decimal digit.
    always_comb begin
        w_bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and register next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        step_d     = step_q;
        val_d      = val_q;
        digits_d   = digits_q;
        led_d      = led_q;
        tag_d      = tag_q;
        tag_vld_d  = tag_vld_q;
        blink_en_d = blink_en_q;
        blank_d    = blank_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    case (wr.wr_sel)
                        2'd0: begin
                            bin_d   = wr.wr_data;
                            val_d   = wr.wr_data;
                            bcd_d   = 16'd0;
                            step_d  = 4'd0;
                            state_d = SHIFT;
                        end
                        2'd1: begin
                            tag_d     = wr.wr_data[7:0];
                            tag_vld_d = 1'b1;
                        end
                        2'd2: begin
                            blink_en_d = wr.wr_data[0];
                            blank_d    = wr.wr_data[1];
                        end
                        default: ; // reserved target: handshake only
                    endcase
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {w_bcd_adj, bin_q} << 1;
                step_d         = step_q + 4'd1;
                if (step_q == 4'd9) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // Digits and LED update together so the display never
                // shows a mix of old and new value.
                digits_d = bcd_q;
                led_d    = val_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Blink timebase; a control write restarts it in the visible phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        phase_d     = phase_q;
        if (w_ctrl_wr) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_TERM) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            step_q      <= '0;
            val_q       <= '0;
            digits_q    <= '0;
            led_q       <= '0;
            tag_q       <= '0;
            tag_vld_q   <= 1'b0;
            blink_en_q  <= 1'b0;
            blank_q     <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            step_q      <= step_d;
            val_q       <= val_d;
            digits_q    <= digits_d;
            led_q       <= led_d;
            tag_q       <= tag_d;
            tag_vld_q   <= tag_vld_d;
            blink_en_q  <= blink_en_d;
            blank_q     <= blank_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // ------------------------------------------------------------------
    // Segment decode (registered digits only)
    // ------------------------------------------------------------------
    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
            4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
            4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
            4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
        endcase
        return g;
    endfunction

    assign w_hide = blank_q || (blink_en_q && phase_q);
    assign LED_B  = led_q;

    always_comb begin
        HEX0 = glyph(digits_q[3:0]);
        HEX1 = (digits_q[15:4] != 12'd0) ? glyph(digits_q[7:4])   : SEG_OFF;
        HEX2 = (digits_q[15:8] != 8'd0)  ? glyph(digits_q[11:8])  : SEG_OFF;
        HEX3 = (digits_q[15:12] != 4'd0) ? glyph(digits_q[15:12]) : SEG_OFF;
        HEX4 = tag_vld_q ? glyph(tag_q[3:0]) : SEG_OFF;
        HEX5 = tag_vld_q ? glyph(tag_q[7:4]) : SEG_OFF;
        if (w_hide) begin
            HEX0 = SEG_OFF;
            HEX1 = SEG_OFF;
            HEX2 = SEG_OFF;
            HEX3 = SEG_OFF;
            HEX4 = SEG_OFF;
            HEX5 = SEG_OFF;
        end
    end

endmodule
`default_nettype wire

// File: doc/hex_output_driver.md
Name: hex_output_driver

Overview:
- Output-side counterpart to the input conditioning path: the debouncer cleans board inputs into the core; this block takes processor result writes out to the board.
- Accepts 10-bit result writes from the processor core over a valid/ready handshake.
- Converts values to decimal with a sequential double-dabble engine and drives HEX3..HEX0, LED_B, and a hex tag on HEX5..HEX4.
- Supports blink and blank controls.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BLINK_HZ, 2, blink rate in Hz; the phase toggles every CLK_HZ/(2*BLINK_HZ) cycles (integer division, minimum 1).

Ports:
- CLK  input  1  system clock (50 MHz board clock).
- RSTb  input  1  asynchronous active-low reset.
- wr_valid  input  1  write request.
- wr_ready  output  1  high when able to accept a write.
- wr_sel  input  2  write target: 0=value, 1=tag, 2=control, 3=reserved.
- wr_data  input  10  write payload.
- LED_B  output  10  last committed value, binary.
- HEX0..HEX5  output  8 each  active-low segments, bit order {dp,g,f,e,d,c,b,a}; dp always 1 (off).

Behaviour:
- Reset (async, RSTb=0):
  - State IDLE; value reg=0; tag invalid; blink_en=0; blank=0; blink counter and phase=0.
  - Outputs: LED_B=0; HEX0=C0 ("0"); HEX1..HEX5=FF; wr_ready=1.
- Handshake:
  - Transfer occurs on a rising CLK edge with wr_valid=1 and wr_ready=1.
  - wr_ready = (state==IDLE), driven combinationally from the state register.
  - A write presented while busy is held off; the master must keep wr_valid and data stable until the transfer.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE, sel=0 accepted: load shift reg with wr_data, clear BCD (16 bits) and step counter, go to SHIFT.
  - SHIFT: each edge adds 3 to every BCD nibble >=5, then shifts {bcd,bin} left 1 and increments the counter. After the 10th step, go to COMMIT.
  - COMMIT: latch BCD digits and LED_B=value atomically, go to IDLE.
  - Result: outputs change exactly 11 edges after the accepting edge; wr_ready is low for 11 cycles. The old display holds until commit.
- sel=1 (tag), accepted in IDLE: tag=wr_data[7:0], tag valid. HEX5=upper nibble, HEX4=lower nibble, hex glyphs, visible the next cycle. wr_data[9:8] ignored.
- sel=2 (control), accepted in IDLE: blink_en=wr_data[0], blank=wr_data[1]. Any control write clears the blink counter and phase to 0, so the display is visible immediately. wr_data[9:2] ignored.
- sel=3: accepted (one-cycle handshake), no effect.
- Decimal display and leading-zero blanking:
  - HEX3=thousands, blanked (FF) if 0.
  - HEX2=hundreds, blanked if thousands and hundreds are 0.
  - HEX1=tens, blanked if all upper three digits are 0.
  - HEX0=units, always shown.
  - Range 0..1023, no overflow possible.
- Glyphs: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Segment outputs are combinational decodes of registered digits; no other combinational path from wr_* to HEX.
- Blink: the counter free-runs; on terminal count it wraps to 0 and toggles phase. When blink_en=1 and phase=1, HEX0..HEX5=FF.
- Blank: blank=1 forces HEX0..HEX5=FF regardless of blink.
- LED_B is never blanked or blinked.
- Reset mid-conversion: aborts immediately to reset values; the partial result is discarded.

Test Plan:
- Reset, then write sel=0 data=1023 -> wr_ready low 11 cycles; at commit HEX3..HEX0=F9,C0,A4,B0; LED_B=3FF; HEX5,HEX4=FF.
- Write sel=0 data=7, then data=100 back-to-back (wr_valid held) -> second accepted on the first cycle wr_ready=1; displays go FF,FF,FF,F8, then FF,F9,C0,C0.
- Write sel=1 data=0x0A5 during an idle period -> next cycle HEX5=88, HEX4=92; decimal digits unchanged.
- With CLK_HZ=8, BLINK_HZ=1, write sel=2 data=1 -> HEX visible 4 cycles, FF 4 cycles, repeating; LED_B steady. Then data=3 -> all HEX=FF constantly.
- Assert RSTb=0 mid-SHIFT (step 5 of value 512) -> immediately HEX0=C0, others FF, LED_B=0, wr_ready=1 after release.
- sel=3 write -> accepted in 1 cycle, all outputs unchanged.
